// File: rtl/event_source_if.sv
// -----------------------------------------------------------------------------
// event_source_if
//   Event handshake between the event producer (event_source) and the game FSM.
//
//   Signals
//     event_out      : producer -> consumer, registered sticky pending bits
//     event_received : consumer -> producer, per-bit acknowledge
//     dropped_cnt    : producer -> consumer, saturating count of coalesced events
//
//   Modports
//     master : producer side (event_source)
//     slave  : consumer side (game FSM)
// -----------------------------------------------------------------------------
interface event_source_if #(
   parameter int EVENT_LEN = 6
);

   logic [EVENT_LEN-1:0] event_out;
   logic [EVENT_LEN-1:0] event_received;
   logic [7:0]           dropped_cnt;

   modport master (
      output event_out,
      output dropped_cnt,
      input  event_received
   );

   modport slave (
      input  event_out,
      input  dropped_cnt,
      output event_received
   );

endinterface

// File: rtl/event_source.sv
// -----------------------------------------------------------------------------
// event_source
//   Producer end of the game-FSM event handshake. Turns key-held levels and a
//   level-dependent gravity timer into sticky pending event bits. Each bit stays
//   set until the game FSM acknowledges it. Provides per-key auto-repeat and a
//   saturating count of events that arrived while already pending.
//
//   Event bit map: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 SPACE, 5 FALL.
//
//   Ports
//     clk          : main game clock
//     rst_n        : asynchronous active-low reset
//     key_held     : per-key level (UP..SPACE), 1 = held
//     level        : current game level, shortens the fall period
//     fall_enable  : 1 = gravity timer runs, 0 = timer holds
//     fall_restart : one-cycle pulse, restarts the gravity period
//     ev           : handshake (event_out, event_received, dropped_cnt)
// -----------------------------------------------------------------------------
module event_source #(
   parameter int         EVENT_LEN    = 6,
   parameter int         LEVEL_LEN    = 4,
   parameter int         BASE_PERIOD  = 12207,
   parameter int         LEVEL_STEP   = 700,
   parameter int         MIN_PERIOD   = 1220,
   parameter int         REPEAT_DELAY = 3000,
   parameter int         REPEAT_RATE  = 600,
   parameter logic [4:0] REPEAT_MASK  = 5'b01111,
   parameter int         CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           key_held,
   input  logic [LEVEL_LEN-1:0] level,
   input  logic                 fall_enable,
   input  logic                 fall_restart,
   event_source_if.master       ev
);

   localparam int NUM_KEYS = 5;
   localparam int FALL_BIT = 5;
   localparam int PW       = CNT_W + LEVEL_LEN;

   typedef logic [CNT_W-1:0] cnt_t;

   // Threshold for level*LEVEL_STEP beyond which the period sits on the floor;
   // comparing against it avoids ever forming a negative period.
   localparam logic [PW-1:0] FLOOR_SPAN  = PW'(BASE_PERIOD - MIN_PERIOD);
   localparam cnt_t          REP_LAST    = cnt_t'(REPEAT_DELAY - 1);
   localparam cnt_t          REP_RELOAD  = cnt_t'(REPEAT_DELAY - REPEAT_RATE);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [NUM_KEYS-1:0]  key_prev;
   cnt_t                 rep_cnt     [NUM_KEYS];
   cnt_t                 fall_cnt;

   // ---------------------------------------------------------------------------
   // Next-state signals
   // ---------------------------------------------------------------------------
   logic [NUM_KEYS-1:0]  key_rise;
   logic [NUM_KEYS-1:0]  rep_fire;
   cnt_t                 rep_cnt_nxt [NUM_KEYS];

   logic [PW-1:0]        level_drop;
   cnt_t                 fall_period;
   logic                 fall_fire;
   cnt_t                 fall_cnt_nxt;

   logic [EVENT_LEN-1:0] set_req;
   logic [EVENT_LEN-1:0] coalesce;
   logic [EVENT_LEN-1:0] event_nxt;
   logic [8:0]           dropped_sum;
   logic [7:0]           dropped_nxt;

   // ---------------------------------------------------------------------------
   // Key edge detection and auto-repeat
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      key_rise = key_held & ~key_prev;
      rep_fire = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         rep_cnt_nxt[k] = '0;
         // The cycle of the rising edge leaves the counter at zero; counting
         // starts on the following held cycle. Release also forces zero.
         if (REPEAT_MASK[k] && key_held[k] && !key_rise[k]) begin
            // Firing as the counter would step onto REPEAT_DELAY puts the first
            // repeat REPEAT_DELAY cycles after the edge, then every REPEAT_RATE.
            if (rep_cnt[k] == REP_LAST) begin
               rep_fire[k]    = 1'b1;
               rep_cnt_nxt[k] = REP_RELOAD;
            end else begin
               rep_cnt_nxt[k] = rep_cnt[k] + cnt_t'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Gravity timer
   // ---------------------------------------------------------------------------
   assign level_drop  = PW'(level) * PW'(LEVEL_STEP);
   assign fall_period = (level_drop >= FLOOR_SPAN) ? cnt_t'(MIN_PERIOD)
                                                   : cnt_t'(PW'(BASE_PERIOD) - level_drop);

   always_comb begin
      fall_fire    = 1'b0;
      fall_cnt_nxt = fall_cnt;
      if (fall_restart) begin
         fall_cnt_nxt = '0;
      end else if (fall_enable) begin
         // '>=' rather than '==' so a level change that shortens the period
         // below the current count fires at once instead of wrapping the counter.
         if (fall_cnt >= fall_period - cnt_t'(1)) begin
            fall_fire    = 1'b1;
            fall_cnt_nxt = '0;
         end else begin
            fall_cnt_nxt = fall_cnt + cnt_t'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pending bits and coalescing count
   // ---------------------------------------------------------------------------
   always_comb begin
      set_req                   = '0;
      set_req[NUM_KEYS-1:0]     = key_rise | rep_fire;
      set_req[FALL_BIT]         = fall_fire;

      // A set overrides a same-cycle ack, so no new event is lost to an ack.
      event_nxt   = (ev.event_out & ~ev.event_received) | set_req;

      // Only a set landing on a bit that stays pending is a lost event.
      coalesce    = set_req & ev.event_out & ~ev.event_received;
      dropped_sum = 9'(ev.dropped_cnt) + 9'($countones(coalesce));
      dropped_nxt = dropped_sum[8] ? 8'hFF : dropped_sum[7:0];
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_prev       <= '0;
         fall_cnt       <= '0;
         ev.event_out   <= '0;
         ev.dropped_cnt <= '0;
         // NOTE: the repeat counters are a handful of flops, not a RAM, so
         // resetting the whole array costs nothing and keeps them defined.
         for (int k = 0; k < NUM_KEYS; k++) begin
            rep_cnt[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register here samples the
         // pre-edge values, independent of statement order.
         key_prev       <= key_held;
         fall_cnt       <= fall_cnt_nxt;
         ev.event_out   <= event_nxt;
         ev.dropped_cnt <= dropped_nxt;
         for (int k = 0; k < NUM_KEYS; k++) begin
            rep_cnt[k] <= rep_cnt_nxt[k];
         end
      end
   end

endmodule

// File: tb/tb_event_source.sv
// -----------------------------------------------------------------------------
// tb_event_source
//   Directed bench for event_source with short periods: BASE_PERIOD=20,
//   LEVEL_STEP=2, MIN_PERIOD=4, REPEAT_DELAY=5, REPEAT_RATE=3.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_event_source;

   localparam int EVENT_LEN = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] key_held;
   logic [3:0] level;
   logic       fall_enable;
   logic       fall_restart;

   int n_tests = 0;
   int n_fail  = 0;

   event_source_if #(.EVENT_LEN(EVENT_LEN)) ev_if ();

   event_source #(
      .EVENT_LEN    (EVENT_LEN),
      .LEVEL_LEN    (4),
      .BASE_PERIOD  (20),
      .LEVEL_STEP   (2),
      .MIN_PERIOD   (4),
      .REPEAT_DELAY (5),
      .REPEAT_RATE  (3),
      .REPEAT_MASK  (5'b01111),
      .CNT_W        (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_held     (key_held),
      .level        (level),
      .fall_enable  (fall_enable),
      .fall_restart (fall_restart),
      .ev           (ev_if)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      key_held             = '0;
      level                = '0;
      fall_enable          = 1'b0;
      fall_restart         = 1'b0;
      ev_if.event_received = '0;
      rst_n                = 1'b0;
      #1;
      check("reset_event_out", int'(ev_if.event_out), 0);
      check("reset_dropped",   int'(ev_if.dropped_cnt), 0);
      ticks(2);
      rst_n = 1'b1;
   endtask

   // Counts cycles until FALL is seen pending, acking it in that same cycle.
   task automatic measure_fall(output int n);
      logic got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         tick();
         n++;
         got = ev_if.event_out[5];
         ev_if.event_received[5] = got;
      end
   endtask

   initial begin
      int n;
      int space_cnt;
      logic exp_left;

      rst_n = 1'b1;
      #2;

      // ---------------- UP: edge then repeats coalesce while unacked --------
      do_reset();
      key_held = 5'b00001;                       // cycle c0
      tick();                                    // c0+1
      check("up_edge_event", int'(ev_if.event_out), 1);
      check("up_edge_dropped", int'(ev_if.dropped_cnt), 0);
      ticks(4);                                  // c0+5
      check("up_before_repeat", int'(ev_if.dropped_cnt), 0);
      tick();                                    // c0+6
      check("up_repeat1", int'(ev_if.dropped_cnt), 1);
      ticks(2);                                  // c0+8
      check("up_between", int'(ev_if.dropped_cnt), 1);
      tick();                                    // c0+9
      check("up_repeat2", int'(ev_if.dropped_cnt), 2);
      ticks(3);                                  // c0+12
      check("up_repeat3", int'(ev_if.dropped_cnt), 3);
      check("up_still_pending", int'(ev_if.event_out), 1);

      // ---------------- LEFT: acked repeats, then release ------------------
      do_reset();
      key_held = 5'b00100;                       // cycle 0
      for (int c = 1; c <= 16; c++) begin
         tick();
         exp_left = (c == 1) || (c == 6) || (c == 9) || (c == 12);
         check($sformatf("left_c%0d", c), int'(ev_if.event_out), exp_left ? 4 : 0);
         ev_if.event_received[2] = exp_left;
         if (c == 13) key_held = 5'b00000;
      end
      check("left_dropped", int'(ev_if.dropped_cnt), 0);

      // ---------------- SPACE: held 40 cycles, never repeats ----------------
      do_reset();
      key_held  = 5'b10000;
      space_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (ev_if.event_out[4]) space_cnt++;
         ev_if.event_received[4] = ev_if.event_out[4];
      end
      check("space_once", space_cnt, 1);
      check("space_dropped", int'(ev_if.dropped_cnt), 0);

      // ---------------- FALL: period vs level -------------------------------
      do_reset();
      level       = 4'd0;
      fall_enable = 1'b1;
      measure_fall(n);  check("fall_l0_first", n, 20);
      measure_fall(n);  check("fall_l0_second", n, 20);
      level = 4'd9;
      measure_fall(n);  check("fall_l9_first", n, 4);
      measure_fall(n);  check("fall_l9_second", n, 4);
      level = 4'd3;
      measure_fall(n);  check("fall_l3_first", n, 14);
      measure_fall(n);  check("fall_l3_second", n, 14);

      // Shorten the period below the running count: fires on the next cycle.
      level = 4'd0;
      tick();
      ev_if.event_received = '0;
      ticks(9);                                  // count now 10
      level = 4'd9;
      measure_fall(n);  check("fall_overrun", n, 1);

      // Restart at count 15 with P=20.
      level = 4'd0;
      tick();
      ev_if.event_received = '0;
      ticks(14);                                 // count now 15
      fall_restart = 1'b1;
      tick();
      fall_restart = 1'b0;
      measure_fall(n);  check("fall_restart", n, 20);

      // Timer paused for 7 cycles delays the fall by exactly 7.
      fall_enable = 1'b0;
      tick();
      ev_if.event_received = '0;
      ticks(6);
      fall_enable = 1'b1;
      measure_fall(n);  check("fall_pause", 7 + n, 27);
      check("fall_dropped", int'(ev_if.dropped_cnt), 0);
      fall_enable = 1'b0;

      // ---------------- Ack vs new edge, multi-bit coalesce -----------------
      do_reset();
      key_held = 5'b01000;                       // c0
      tick();                                    // c1
      check("right_edge", int'(ev_if.event_out), 8);
      key_held = 5'b00000;
      tick();                                    // c2
      check("right_held_pending", int'(ev_if.event_out), 8);
      key_held             = 5'b01000;
      ev_if.event_received = 6'h08;              // ack and new edge together
      tick();                                    // c3
      check("ack_edge_event", int'(ev_if.event_out), 8);
      check("ack_edge_dropped", int'(ev_if.dropped_cnt), 0);
      tick();                                    // c4
      check("ack_clears", int'(ev_if.event_out), 0);
      tick();                                    // c5, ack of an idle bit
      check("ack_idle_bit", int'(ev_if.event_out), 0);
      ev_if.event_received = '0;
      key_held = 5'b00011;
      tick();                                    // c6
      check("multi_set", int'(ev_if.event_out), 3);
      check("multi_set_dropped", int'(ev_if.dropped_cnt), 0);
      key_held = 5'b00000;
      tick();                                    // c7
      key_held = 5'b00011;
      tick();                                    // c8
      check("multi_coalesce", int'(ev_if.dropped_cnt), 2);
      check("multi_coalesce_event", int'(ev_if.event_out), 3);

      // ---------------- Asynchronous reset mid-repeat -----------------------
      ticks(6);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_event", int'(ev_if.event_out), 0);
      check("async_reset_dropped", int'(ev_if.dropped_cnt), 0);
      ticks(2);
      check("reset_hold_event", int'(ev_if.event_out), 0);
      rst_n = 1'b1;
      tick();
      check("post_reset_edge", int'(ev_if.event_out), 3);
      check("post_reset_dropped", int'(ev_if.dropped_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
